// File: rtl/mem_access_unit_pkg.sv
// Shared pipeline definitions: MEM-stage access FSM encoding and MEM control bit positions.
// Imported by the data-cache access unit and its line storage.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_MISS = 2'd1,
        ST_WR_THRU = 2'd2
    } mau_state_t;

    localparam int LOAD_BIT  = 0;
    localparam int STORE_BIT = 1;

    localparam int WORD_W = 32;

endpackage

// File: rtl/dm_line_array.sv
// Direct-mapped line storage: tag, valid and one data word per line.
// Read is combinational on i_idx; write commits on the rising edge. Only valid bits are reset.
module dm_line_array #(
    parameter int LINES = 16,
    parameter int TAG_W = 26,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_wr_en,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic [31:0]      i_wr_dat,
    output logic             o_rd_vld,
    output logic [TAG_W-1:0] o_rd_tag,
    output logic [31:0]      o_rd_dat
);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag [LINES];
    logic [31:0]      r_data [LINES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_idx] <= 1'b1;
        end
    end

    // Tag and data never need a reset value: they are only read behind a valid bit.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_idx]  <= i_wr_tag;
            r_data[i_idx] <= i_wr_dat;
        end
    end

    assign o_rd_vld = r_valid[i_idx];
    assign o_rd_tag = r_tag[i_idx];
    assign o_rd_dat = r_data[i_idx];

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage with a direct-mapped, write-through, no-write-allocate data cache in front of backing memory.
// Hits complete in zero added cycles; misses and stores hold stall_out until the memory acks.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int LINES = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cntrl_m_in,
    input  logic [3:0]       cntrl_w_in,
    input  logic [3:0]       Z_in,
    input  logic [31:0]      alu_in,
    input  logic [31:0]      wdata_in,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      alu_out,
    output logic [31:0]      mem_out,
    output logic [3:0]       Z_out,
    output logic [3:0]       cntrl_w_out,
    output logic             stall_out,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    mau_state_t r_state, w_state_nxt;

    logic             r_done;
    logic             r_fill_done;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    logic [IDX_W-1:0] w_index;
    logic [TAG_W-1:0] w_tag;
    logic             w_load;
    logic             w_store;
    logic             w_hit;
    logic             w_rd_vld;
    logic [TAG_W-1:0] w_rd_tag;
    logic [31:0]      w_rd_dat;
    logic             w_wr_en;
    logic [31:0]      w_wr_dat;
    logic             w_stall;
    logic             w_hit_inc;
    logic             w_miss_inc;
    logic             w_done_set;
    logic             w_fill_set;

    assign w_index = alu_in[IDX_W+1:2];
    assign w_tag   = alu_in[31:IDX_W+2];
    assign w_load  = cntrl_m_in[LOAD_BIT];
    assign w_store = cntrl_m_in[STORE_BIT] & ~cntrl_m_in[LOAD_BIT];
    assign w_hit   = w_rd_vld && (w_rd_tag == w_tag);

    dm_line_array #(
        .LINES (LINES),
        .TAG_W (TAG_W),
        .IDX_W (IDX_W)
    ) u_lines (
        .clk      (clk),
        .rst      (rst),
        .i_idx    (w_index),
        .i_wr_en  (w_wr_en),
        .i_wr_tag (w_tag),
        .i_wr_dat (w_wr_dat),
        .o_rd_vld (w_rd_vld),
        .o_rd_tag (w_rd_tag),
        .o_rd_dat (w_rd_dat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_dat    = wdata_in;
        w_hit_inc   = 1'b0;
        w_miss_inc  = 1'b0;
        w_done_set  = 1'b0;
        w_fill_set  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    if (w_hit) begin
                        // The hit that closes a refill was already counted as a miss.
                        w_hit_inc = ~r_fill_done;
                    end else begin
                        w_stall     = 1'b1;
                        w_miss_inc  = 1'b1;
                        w_state_nxt = ST_RD_MISS;
                    end
                end else if (w_store && !r_done) begin
                    w_stall     = 1'b1;
                    w_wr_en     = w_hit;
                    w_state_nxt = ST_WR_THRU;
                end
            end
            ST_RD_MISS: begin
                w_stall = 1'b1;
                if (mem_ack) begin
                    w_wr_en     = 1'b1;
                    w_wr_dat    = mem_rdata;
                    w_fill_set  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR_THRU: begin
                w_stall = 1'b1;
                if (mem_ack) begin
                    w_done_set  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Completion flags live for exactly one IDLE cycle after the ack returns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done      <= 1'b0;
            r_fill_done <= 1'b0;
        end else begin
            if (w_done_set) begin
                r_done <= 1'b1;
            end else if (r_state == ST_IDLE) begin
                r_done <= 1'b0;
            end
            if (w_fill_set) begin
                r_fill_done <= 1'b1;
            end else if (r_state == ST_IDLE) begin
                r_fill_done <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit_inc && (r_hit_cnt != {CNT_W{1'b1}})) begin
                r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            end
            if (w_miss_inc && (r_miss_cnt != {CNT_W{1'b1}})) begin
                r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end
        end
    end

    assign mem_req     = (r_state != ST_IDLE);
    assign mem_we      = (r_state == ST_WR_THRU);
    assign mem_addr    = {alu_in[31:2], 2'b00};
    assign mem_wdata   = wdata_in;
    assign alu_out     = alu_in;
    assign mem_out     = w_rd_dat;
    assign Z_out       = Z_in;
    assign stall_out   = w_stall;
    assign cntrl_w_out = w_stall ? 4'b0000 : cntrl_w_in;
    assign hit_cnt     = r_hit_cnt;
    assign miss_cnt    = r_miss_cnt;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; a second instance with 2-bit counters shares all inputs
// so counter saturation is reached in a few accesses.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  cntrl_m_in = '0;
    logic [3:0]  cntrl_w_in = '0;
    logic [3:0]  Z_in = '0;
    logic [31:0] alu_in = '0;
    logic [31:0] wdata_in = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        mem_req, mem_we, stall_out;
    logic [31:0] mem_addr, mem_wdata, alu_out, mem_out;
    logic [3:0]  Z_out, cntrl_w_out;
    logic [15:0] hit_cnt, miss_cnt;

    logic        s_req, s_we, s_stall;
    logic [31:0] s_addr, s_wdata, s_alu, s_out;
    logic [3:0]  s_z, s_cw;
    logic [1:0]  s_hit, s_miss;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.LINES(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst_n), .cntrl_m_in(cntrl_m_in), .cntrl_w_in(cntrl_w_in),
        .Z_in(Z_in), .alu_in(alu_in), .wdata_in(wdata_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .alu_out(alu_out), .mem_out(mem_out),
        .Z_out(Z_out), .cntrl_w_out(cntrl_w_out), .stall_out(stall_out),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    mem_access_unit #(.LINES(16), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst_n), .cntrl_m_in(cntrl_m_in), .cntrl_w_in(cntrl_w_in),
        .Z_in(Z_in), .alu_in(alu_in), .wdata_in(wdata_in),
        .mem_req(s_req), .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .alu_out(s_alu), .mem_out(s_out),
        .Z_out(s_z), .cntrl_w_out(s_cw), .stall_out(s_stall),
        .hit_cnt(s_hit), .miss_cnt(s_miss)
    );

    // Presents one access until stall_out drops; acks on the ack_dly-th request cycle.
    task automatic run_access(input logic [1:0] m, input logic [31:0] addr, input logic [31:0] wd,
                              input int ack_dly, input logic [31:0] rd,
                              output int n_stall, output int n_req, output int n_we,
                              output int n_bad, output int n_cwbad,
                              output logic [31:0] out_dat, output logic [3:0] out_cw, output bit tmo);
        n_stall = 0; n_req = 0; n_we = 0; n_bad = 0; n_cwbad = 0; tmo = 1'b1;
        out_dat = '0; out_cw = '0;
        @(posedge clk); #1;
        cntrl_m_in = m; alu_in = addr; wdata_in = wd; cntrl_w_in = 4'hA; Z_in = 4'h3;
        for (int c = 0; c < 60; c++) begin
            mem_ack = 1'b0;
            if (mem_req) begin
                n_req++;
                if (mem_we) n_we++;
                if (mem_addr !== {addr[31:2], 2'b00}) n_bad++;
                if (mem_we && mem_wdata !== wd) n_bad++;
                mem_ack = (n_req == ack_dly);
                mem_rdata = rd;
            end
            @(negedge clk);
            if (stall_out) begin
                n_stall++;
                if (cntrl_w_out !== 4'h0) n_cwbad++;
            end else begin
                out_dat = mem_out;
                out_cw = cntrl_w_out;
                tmo = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cntrl_m_in = 2'b00;
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0h want 0", mem_req); end
        n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0h want 0", mem_we); end
        n_chk++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0h want 0", stall_out); end
        n_chk++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
            n_fail++; $display("FAIL reset_cnt: got hit %0h miss %0h want 0 0", hit_cnt, miss_cnt); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_load_miss();
        int ns, nr, nw, nb, nc; logic [31:0] od; logic [3:0] ocw; bit to;
        run_access(2'b01, 32'h40, 32'h0, 3, 32'hDEADBEEF, ns, nr, nw, nb, nc, od, ocw, to);
        n_chk++; if (to) begin n_fail++; $display("FAIL miss_timeout: got timeout want completion"); end
        n_chk++; if (ns != 4) begin n_fail++; $display("FAIL miss_stall_cycles: got %0d want 4", ns); end
        n_chk++; if (nr != 3 || nw != 0 || nb != 0) begin
            n_fail++; $display("FAIL miss_req: got req %0d we %0d bad %0d want 3 0 0", nr, nw, nb); end
        n_chk++; if (nc != 0) begin n_fail++; $display("FAIL miss_cw_stalled: got %0d nonzero cycles want 0", nc); end
        n_chk++; if (od !== 32'hDEADBEEF) begin n_fail++; $display("FAIL miss_data: got %h want deadbeef", od); end
        n_chk++; if (ocw !== 4'hA) begin n_fail++; $display("FAIL miss_cw_done: got %h want a", ocw); end
        n_chk++; if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin
            n_fail++; $display("FAIL miss_cnt: got miss %0d hit %0d want 1 0", miss_cnt, hit_cnt); end
    endtask

    task automatic test_load_hit();
        int ns, nr, nw, nb, nc; logic [31:0] od; logic [3:0] ocw; bit to;
        run_access(2'b01, 32'h40, 32'h0, 0, 32'h0, ns, nr, nw, nb, nc, od, ocw, to);
        n_chk++; if (to || ns != 0 || nr != 0) begin
            n_fail++; $display("FAIL hit_nostall: got to %0d stall %0d req %0d want 0 0 0", to, ns, nr); end
        n_chk++; if (od !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hit_data: got %h want deadbeef", od); end
        n_chk++; if (hit_cnt !== 16'd1) begin n_fail++; $display("FAIL hit_cnt1: got %0d want 1", hit_cnt); end
        // low address bits ignored, cntrl 11 acts as a load
        run_access(2'b11, 32'h43, 32'h0, 0, 32'h0, ns, nr, nw, nb, nc, od, ocw, to);
        n_chk++; if (to || ns != 0 || nr != 0 || od !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL hit_ld11: got stall %0d req %0d data %h want 0 0 deadbeef", ns, nr, od); end
        n_chk++; if (hit_cnt !== 16'd2 || miss_cnt !== 16'd1) begin
            n_fail++; $display("FAIL hit_cnt2: got hit %0d miss %0d want 2 1", hit_cnt, miss_cnt); end
    endtask

    task automatic test_store();
        int ns, nr, nw, nb, nc; logic [31:0] od; logic [3:0] ocw; bit to;
        run_access(2'b10, 32'h40, 32'h12345678, 2, 32'h0, ns, nr, nw, nb, nc, od, ocw, to);
        n_chk++; if (to || ns != 3) begin n_fail++; $display("FAIL st_stall: got to %0d stall %0d want 0 3", to, ns); end
        n_chk++; if (nr != 2 || nw != 2 || nb != 0 || nc != 0) begin
            n_fail++; $display("FAIL st_req: got req %0d we %0d bad %0d cw %0d want 2 2 0 0", nr, nw, nb, nc); end
        n_chk++; if (ocw !== 4'hA) begin n_fail++; $display("FAIL st_cw_done: got %h want a", ocw); end
        @(negedge clk);
        n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL st_reissue: got req %0h want 0", mem_req); end
        n_chk++; if (hit_cnt !== 16'd2 || miss_cnt !== 16'd1) begin
            n_fail++; $display("FAIL st_cnt: got hit %0d miss %0d want 2 1", hit_cnt, miss_cnt); end
        run_access(2'b01, 32'h40, 32'h0, 0, 32'h0, ns, nr, nw, nb, nc, od, ocw, to);
        n_chk++; if (to || ns != 0 || od !== 32'h12345678) begin
            n_fail++; $display("FAIL st_hit_update: got stall %0d data %h want 0 12345678", ns, od); end
        // store miss must not allocate
        run_access(2'b10, 32'hC4, 32'h77777777, 1, 32'h0, ns, nr, nw, nb, nc, od, ocw, to);
        n_chk++; if (to || ns != 2 || nw != 1) begin
            n_fail++; $display("FAIL st_miss: got stall %0d we %0d want 2 1", ns, nw); end
        run_access(2'b01, 32'hC4, 32'h0, 1, 32'h55AA55AA, ns, nr, nw, nb, nc, od, ocw, to);
        n_chk++; if (to || ns != 2 || od !== 32'h55AA55AA) begin
            n_fail++; $display("FAIL st_no_alloc: got stall %0d data %h want 2 55aa55aa", ns, od); end
        n_chk++; if (hit_cnt !== 16'd3 || miss_cnt !== 16'd2) begin
            n_fail++; $display("FAIL st_cnt2: got hit %0d miss %0d want 3 2", hit_cnt, miss_cnt); end
    endtask

    task automatic test_conflict();
        int ns, nr, nw, nb, nc; logic [31:0] od; logic [3:0] ocw; bit to;
        run_access(2'b01, 32'h80, 32'h0, 1, 32'hCAFEF00D, ns, nr, nw, nb, nc, od, ocw, to);
        n_chk++; if (to || ns != 2 || od !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL conf_miss80: got stall %0d data %h want 2 cafef00d", ns, od); end
        run_access(2'b01, 32'h80, 32'h0, 0, 32'h0, ns, nr, nw, nb, nc, od, ocw, to);
        n_chk++; if (to || ns != 0 || od !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL conf_hit80: got stall %0d data %h want 0 cafef00d", ns, od); end
        run_access(2'b01, 32'h40, 32'h0, 2, 32'h12345678, ns, nr, nw, nb, nc, od, ocw, to);
        n_chk++; if (to || ns != 3 || od !== 32'h12345678) begin
            n_fail++; $display("FAIL conf_miss40: got stall %0d data %h want 3 12345678", ns, od); end
        n_chk++; if (hit_cnt !== 16'd4 || miss_cnt !== 16'd4) begin
            n_fail++; $display("FAIL conf_cnt: got hit %0d miss %0d want 4 4", hit_cnt, miss_cnt); end
    endtask

    task automatic test_nop();
        @(posedge clk); #1;
        cntrl_m_in = 2'b00; alu_in = 32'h200; cntrl_w_in = 4'h5; Z_in = 4'h9; mem_ack = 1'b1;
        @(negedge clk);
        n_chk++; if (stall_out !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL nop_idle: got stall %0h req %0h want 0 0", stall_out, mem_req); end
        n_chk++; if (cntrl_w_out !== 4'h5 || alu_out !== 32'h200 || Z_out !== 4'h9) begin
            n_fail++; $display("FAIL nop_pass: got cw %h alu %h z %h want 5 200 9", cntrl_w_out, alu_out, Z_out); end
        @(posedge clk); #1 mem_ack = 1'b0;
        @(negedge clk);
        n_chk++; if (mem_req !== 1'b0 || stall_out !== 1'b0) begin
            n_fail++; $display("FAIL nop_ack_ignored: got req %0h stall %0h want 0 0", mem_req, stall_out); end
    endtask

    task automatic test_reset_mid();
        int ns, nr, nw, nb, nc; logic [31:0] od; logic [3:0] ocw; bit to;
        @(posedge clk); #1;
        cntrl_m_in = 2'b01; alu_in = 32'h200;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_chk++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_inflight: got req %0h want 1", mem_req); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req_drop: got req %0h want 0", mem_req); end
        cntrl_m_in = 2'b00;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        @(posedge clk); #1 mem_ack = 1'b0;
        @(negedge clk);
        n_chk++; if (mem_req !== 1'b0 || miss_cnt !== 16'd0 || hit_cnt !== 16'd0) begin
            n_fail++; $display("FAIL rmid_after: got req %0h miss %0d hit %0d want 0 0 0", mem_req, miss_cnt, hit_cnt); end
        run_access(2'b01, 32'h40, 32'h0, 1, 32'h11112222, ns, nr, nw, nb, nc, od, ocw, to);
        n_chk++; if (to || ns != 2 || od !== 32'h11112222) begin
            n_fail++; $display("FAIL rmid_remiss: got stall %0d data %h want 2 11112222", ns, od); end
        n_chk++; if (miss_cnt !== 16'd1) begin n_fail++; $display("FAIL rmid_cnt: got %0d want 1", miss_cnt); end
    endtask

    task automatic test_saturate();
        int ns, nr, nw, nb, nc; logic [31:0] od; logic [3:0] ocw; bit to;
        logic [31:0] addrs [4];
        addrs[0] = 32'h80; addrs[1] = 32'h40; addrs[2] = 32'h80; addrs[3] = 32'h40;
        for (int i = 0; i < 4; i++)
            run_access(2'b01, addrs[i], 32'h0, 1, 32'h100 + i, ns, nr, nw, nb, nc, od, ocw, to);
        n_chk++; if (miss_cnt !== 16'd5) begin n_fail++; $display("FAIL sat_miss_main: got %0d want 5", miss_cnt); end
        n_chk++; if (s_miss !== 2'b11) begin n_fail++; $display("FAIL sat_miss: got %0d want 3", s_miss); end
        for (int i = 0; i < 4; i++)
            run_access(2'b01, 32'h40, 32'h0, 0, 32'h0, ns, nr, nw, nb, nc, od, ocw, to);
        n_chk++; if (hit_cnt !== 16'd4 || od !== 32'h103) begin
            n_fail++; $display("FAIL sat_hit_main: got hit %0d data %h want 4 103", hit_cnt, od); end
        n_chk++; if (s_hit !== 2'b11 || s_miss !== 2'b11) begin
            n_fail++; $display("FAIL sat_hold: got hit %0d miss %0d want 3 3", s_hit, s_miss); end
    endtask

    initial begin
        #2;
        test_reset();
        test_load_miss();
        test_load_hit();
        test_store();
        test_conflict();
        test_nop();
        test_reset_mid();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
